// File: rtl/cache_fill_pkg.sv
// Shared types, default parameters and width helpers for the cache miss-fill controller.
package cache_fill_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StTag
   } fill_state_e;

   localparam int unsigned DefAddrW = 16;
   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefWords = 8;
   localparam int unsigned DefCwf   = 0;

   // Byte-offset bits inside one memory word.
   function automatic int unsigned calc_boff(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int unsigned calc_woff(input int unsigned words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Tag-logic, memory and data/tag-array signals of the fill controller.
interface cache_fill_ctrl_if
   import cache_fill_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned WORDS  = DefWords
);
   localparam int unsigned WOFF = calc_woff(WORDS);

   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic              mem_req_ready;
   logic [DATA_W-1:0] memory_data;
   logic              memory_data_valid;
   logic              mem_req_valid;
   logic [ADDR_W-1:0] memory_address;
   logic              fsm_busy;
   logic              write_data_array;
   logic [WOFF-1:0]   word_num;
   logic [DATA_W-1:0] fill_data;
   logic              write_tag_array;
   logic              crit_word_valid;

   modport master (
      input  miss_detected, miss_address, mem_req_ready, memory_data, memory_data_valid,
      output mem_req_valid, memory_address, fsm_busy, write_data_array, word_num, fill_data,
             write_tag_array, crit_word_valid
   );

   modport slave (
      output miss_detected, miss_address, mem_req_ready, memory_data, memory_data_valid,
      input  mem_req_valid, memory_address, fsm_busy, write_data_array, word_num, fill_data,
             write_tag_array, crit_word_valid
   );

endinterface

// File: rtl/fill_word_ctr.sv
// Word counter for the fill controller: synchronous clear, increment, saturates at MaxVal.
module fill_word_ctr #(
   parameter int unsigned CntW   = 4,
   parameter int unsigned MaxVal = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_clr,
   input  logic            i_inc,
   output logic [CntW-1:0] o_cnt
);

   logic [CntW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt < CntW'(MaxVal))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss-fill controller: pipelined block read from memory, data-array writes,
// then a single tag/valid write. Optional critical-word-first wrap order.
module cache_fill_ctrl
   import cache_fill_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned WORDS  = DefWords,
   parameter int unsigned CWF    = DefCwf
) (
   input logic               clk,
   input logic               rst,
   cache_fill_ctrl_if.master io_bus
);

   localparam int unsigned BOFF = calc_boff(DATA_W);
   localparam int unsigned WOFF = calc_woff(WORDS);
   localparam int unsigned LOW  = BOFF + WOFF;
   localparam logic [WOFF:0] CntMax = (WOFF + 1)'(WORDS);
   localparam logic [ADDR_W-1:0] BaseMask = {{(ADDR_W - LOW){1'b1}}, {LOW{1'b0}}};

   fill_state_e       r_state;
   fill_state_e       w_state_next;
   logic [ADDR_W-1:0] r_base;
   logic [WOFF-1:0]   r_start;
   logic [WOFF:0]     w_req_cnt;
   logic [WOFF:0]     w_rsp_cnt;
   logic [WOFF-1:0]   w_req_word;
   logic              w_start_fill;
   logic              w_issue;
   logic              w_req_fire;
   logic              w_accept;
   logic              w_last_rsp;

   assign w_start_fill = (r_state == StIdle) && io_bus.miss_detected;
   assign w_issue      = (r_state == StFill) && (w_req_cnt < CntMax);
   assign w_req_fire   = w_issue && io_bus.mem_req_ready;
   assign w_accept     = (r_state == StFill) && io_bus.memory_data_valid &&
                         (w_rsp_cnt < w_req_cnt);
   assign w_last_rsp   = w_accept && (w_rsp_cnt == CntMax - 1'b1);

   fill_word_ctr #(
      .CntW   (WOFF + 1),
      .MaxVal (WORDS)
   ) u_req_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start_fill),
      .i_inc (w_req_fire),
      .o_cnt (w_req_cnt)
   );

   fill_word_ctr #(
      .CntW   (WOFF + 1),
      .MaxVal (WORDS)
   ) u_rsp_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start_fill),
      .i_inc (w_accept),
      .o_cnt (w_rsp_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_base  <= '0;
         r_start <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_start_fill) begin
            r_base  <= io_bus.miss_address & BaseMask;
            r_start <= (CWF != 0) ? io_bus.miss_address[LOW-1:BOFF] : '0;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (io_bus.miss_detected) w_state_next = StFill;
         StFill:  if (w_last_rsp) w_state_next = StTag;
         StTag:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Word index is WOFF bits wide so the wrap never carries into the tag bits.
   assign w_req_word = r_start + w_req_cnt[WOFF-1:0];

   assign io_bus.mem_req_valid    = w_issue;
   assign io_bus.memory_address   = r_base | (ADDR_W'(w_req_word) << BOFF);
   assign io_bus.write_data_array = w_accept;
   assign io_bus.word_num         = r_start + w_rsp_cnt[WOFF-1:0];
   assign io_bus.fill_data        = io_bus.memory_data;
   assign io_bus.crit_word_valid  = w_accept && (w_rsp_cnt == '0);
   assign io_bus.write_tag_array  = (r_state == StTag);
   assign io_bus.fsm_busy         = (r_state != StIdle) || io_bus.miss_detected;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: three instances (CWF=0, CWF=1, 32-bit/4-word CWF=1) checked
// every cycle against a queue-based block-fill model, plus literal request/write tables.
module tb_cache_fill_ctrl;

   localparam int Lat = 3;

   logic clk;
   logic rst;

   logic        miss_ab, rdy_ab, dv_ab;
   logic [15:0] addr_ab, data_ab;
   logic        miss_c, rdy_c, dv_c;
   logic [31:0] addr_c, data_c;
   logic        spur_ab, rand_rdy;
   int          cyc;

   int n_chk;
   int n_fail;

   cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) if_a ();
   cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) if_b ();
   cache_fill_ctrl_if #(.ADDR_W(32), .DATA_W(32), .WORDS(4)) if_c ();

   assign if_a.miss_detected     = miss_ab;
   assign if_a.miss_address      = addr_ab;
   assign if_a.mem_req_ready     = rdy_ab;
   assign if_a.memory_data       = data_ab;
   assign if_a.memory_data_valid = dv_ab;
   assign if_b.miss_detected     = miss_ab;
   assign if_b.miss_address      = addr_ab;
   assign if_b.mem_req_ready     = rdy_ab;
   assign if_b.memory_data       = data_ab;
   assign if_b.memory_data_valid = dv_ab;
   assign if_c.miss_detected     = miss_c;
   assign if_c.miss_address      = addr_c;
   assign if_c.mem_req_ready     = rdy_c;
   assign if_c.memory_data       = data_c;
   assign if_c.memory_data_valid = dv_c;

   cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .CWF(0)) u_dut_a (
      .clk    (clk),
      .rst    (rst),
      .io_bus (if_a)
   );
   cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .CWF(1)) u_dut_b (
      .clk    (clk),
      .rst    (rst),
      .io_bus (if_b)
   );
   cache_fill_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS(4), .CWF(1)) u_dut_c (
      .clk    (clk),
      .rst    (rst),
      .io_bus (if_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: 0 idle, 1 filling, 2 tag write; pending requests/writes kept as queues.
   string       nm_p    [3] = '{"A", "B", "C"};
   int          words_p [3] = '{8, 8, 4};
   int          bytes_p [3] = '{2, 2, 4};
   int          cwf_p   [3] = '{0, 1, 1};
   int          phase   [3];
   int          outs    [3];
   bit          first   [3];
   logic [31:0] req_q   [3][$];
   int          wr_q    [3][$];
   int          due_q   [2][$];
   logic [31:0] cap_a   [3][$];
   int          cap_w   [3][$];
   int          n_tag   [3];
   int          n_crit  [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(
      input int i, input logic m_rst, input logic m_miss, input logic [31:0] m_addr,
      input logic m_rdy, input logic m_dv, input logic [31:0] m_data,
      input logic o_rv, input logic [31:0] o_addr, input logic o_busy, input logic o_wr,
      input logic [31:0] o_wn, input logic [31:0] o_fd, input logic o_tag, input logic o_crit
   );
      bit exp_rv, acc;
      int st;
      logic [31:0] base;
      if (o_rv && m_rdy) cap_a[i].push_back(o_addr);
      if (o_wr) cap_w[i].push_back(int'(o_wn));
      if (o_tag) n_tag[i]++;
      if (o_crit) n_crit[i]++;
      if (m_rst) begin
         chk({nm_p[i], ".rst_rv"}, 32'(o_rv), 0);
         chk({nm_p[i], ".rst_addr"}, o_addr, 0);
         chk({nm_p[i], ".rst_wr"}, 32'(o_wr), 0);
         chk({nm_p[i], ".rst_wn"}, o_wn, 0);
         chk({nm_p[i], ".rst_tag"}, 32'(o_tag), 0);
         chk({nm_p[i], ".rst_crit"}, 32'(o_crit), 0);
         chk({nm_p[i], ".rst_busy"}, 32'(o_busy), 32'(m_miss));
         phase[i] = 0;
         req_q[i].delete();
         wr_q[i].delete();
         return;
      end
      exp_rv = (phase[i] == 1) && (req_q[i].size() > 0);
      acc    = (phase[i] == 1) && m_dv && (outs[i] > 0);
      chk({nm_p[i], ".busy"}, 32'(o_busy), 32'((phase[i] != 0) || m_miss));
      chk({nm_p[i], ".req_valid"}, 32'(o_rv), 32'(exp_rv));
      if (exp_rv) chk({nm_p[i], ".req_addr"}, o_addr, req_q[i][0]);
      chk({nm_p[i], ".wr"}, 32'(o_wr), 32'(acc));
      if (acc) begin
         chk({nm_p[i], ".word_num"}, o_wn, 32'(wr_q[i][0]));
         chk({nm_p[i], ".fill_data"}, o_fd, m_data);
      end
      chk({nm_p[i], ".tag"}, 32'(o_tag), 32'(phase[i] == 2));
      chk({nm_p[i], ".crit"}, 32'(o_crit), 32'(acc && first[i]));
      case (phase[i])
         0: if (m_miss) begin
            base = m_addr & ~32'(words_p[i] * bytes_p[i] - 1);
            st = (cwf_p[i] != 0) ? (int'(m_addr) / bytes_p[i]) % words_p[i] : 0;
            for (int k = 0; k < words_p[i]; k++) begin
               req_q[i].push_back(base + 32'(((st + k) % words_p[i]) * bytes_p[i]));
               wr_q[i].push_back((st + k) % words_p[i]);
            end
            outs[i]  = 0;
            first[i] = 1'b1;
            phase[i] = 1;
         end
         1: begin
            if (acc) begin
               void'(wr_q[i].pop_front());
               outs[i]--;
               first[i] = 1'b0;
            end
            if (exp_rv && m_rdy) begin
               void'(req_q[i].pop_front());
               outs[i]++;
               if (i != 1) due_q[(i == 2) ? 1 : 0].push_back(cyc + Lat);
            end
            if (acc && (wr_q[i].size() == 0)) phase[i] = 2;
         end
         default: phase[i] = 0;
      endcase
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step(0, rst, if_a.miss_detected, 32'(if_a.miss_address), if_a.mem_req_ready,
                    if_a.memory_data_valid, 32'(if_a.memory_data), if_a.mem_req_valid,
                    32'(if_a.memory_address), if_a.fsm_busy, if_a.write_data_array,
                    32'(if_a.word_num), 32'(if_a.fill_data), if_a.write_tag_array,
                    if_a.crit_word_valid);
         model_step(1, rst, if_b.miss_detected, 32'(if_b.miss_address), if_b.mem_req_ready,
                    if_b.memory_data_valid, 32'(if_b.memory_data), if_b.mem_req_valid,
                    32'(if_b.memory_address), if_b.fsm_busy, if_b.write_data_array,
                    32'(if_b.word_num), 32'(if_b.fill_data), if_b.write_tag_array,
                    if_b.crit_word_valid);
         model_step(2, rst, if_c.miss_detected, if_c.miss_address, if_c.mem_req_ready,
                    if_c.memory_data_valid, if_c.memory_data, if_c.mem_req_valid,
                    if_c.memory_address, if_c.fsm_busy, if_c.write_data_array,
                    32'(if_c.word_num), if_c.fill_data, if_c.write_tag_array,
                    if_c.crit_word_valid);
      end
   end

   // Memory: fixed latency after each accepted request, in order; random data.
   initial begin
      cyc = 0;
      dv_ab = 1'b0; data_ab = '0; rdy_ab = 1'b1;
      dv_c = 1'b0; data_c = '0; rdy_c = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         data_ab = 16'($urandom);
         data_c  = $urandom;
         rdy_ab  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if ((due_q[0].size() > 0) && (due_q[0][0] <= cyc)) begin
            void'(due_q[0].pop_front());
            dv_ab = 1'b1;
         end else begin
            dv_ab = spur_ab;
         end
         if ((due_q[1].size() > 0) && (due_q[1][0] <= cyc)) begin
            void'(due_q[1].pop_front());
            dv_c = 1'b1;
         end else begin
            dv_c = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      for (int i = 0; i < 3; i++) begin
         cap_a[i].delete();
         cap_w[i].delete();
         n_tag[i]  = 0;
         n_crit[i] = 0;
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (((phase[0] != 0) || (phase[1] != 0) || (phase[2] != 0)) && (t < 300)) begin
         step();
         t++;
      end
      chk({name, ".idle_timeout"}, 32'(t >= 300), 0);
   endtask

   logic [15:0] b_addr [8] = '{16'h1236, 16'h1238, 16'h123A, 16'h123C,
                               16'h123E, 16'h1230, 16'h1232, 16'h1234};
   int          b_wn   [8] = '{3, 4, 5, 6, 7, 0, 1, 2};
   logic [31:0] c_addr [4] = '{32'h100C, 32'h1000, 32'h1004, 32'h1008};
   int          c_wn   [4] = '{3, 0, 1, 2};

   initial begin
      int t;
      n_chk = 0; n_fail = 0;
      rst = 1'b1; miss_ab = 1'b0; addr_ab = '0; miss_c = 1'b0; addr_c = '0;
      spur_ab = 1'b0; rand_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         phase[i] = 0; outs[i] = 0; first[i] = 1'b0;
      end
      clear_caps();
      repeat (3) step();
      rst = 1'b0;
      step();

      // Plain fill, both orders.
      miss_ab = 1'b1; addr_ab = 16'h1236;
      step();
      miss_ab = 1'b0;
      wait_idle("fill1");
      chk("fill1.A.nreq", cap_a[0].size(), 8);
      chk("fill1.B.nreq", cap_a[1].size(), 8);
      chk("fill1.A.nwr", cap_w[0].size(), 8);
      chk("fill1.B.nwr", cap_w[1].size(), 8);
      if ((cap_a[0].size() == 8) && (cap_a[1].size() == 8)) begin
         for (int k = 0; k < 8; k++) begin
            chk("fill1.A.addr_tbl", cap_a[0][k], 32'h1230 + 32'(2 * k));
            chk("fill1.B.addr_tbl", cap_a[1][k], 32'(b_addr[k]));
         end
      end
      if ((cap_w[0].size() == 8) && (cap_w[1].size() == 8)) begin
         for (int k = 0; k < 8; k++) begin
            chk("fill1.A.wn_tbl", 32'(cap_w[0][k]), 32'(k));
            chk("fill1.B.wn_tbl", 32'(cap_w[1][k]), 32'(b_wn[k]));
         end
      end
      chk("fill1.A.ntag", n_tag[0], 1);
      chk("fill1.B.ntag", n_tag[1], 1);
      chk("fill1.B.ncrit", n_crit[1], 1);
      clear_caps();

      // Random ready stalls with spurious responses in IDLE and early FILL.
      rand_rdy = 1'b1; spur_ab = 1'b1;
      step();
      spur_ab = 1'b0;
      step();
      miss_ab = 1'b1; addr_ab = 16'h4A58;
      step();
      miss_ab = 1'b0; spur_ab = 1'b1;
      step();
      spur_ab = 1'b0;
      wait_idle("stall");
      rand_rdy = 1'b0;
      chk("stall.A.nwr", cap_w[0].size(), 8);
      chk("stall.B.nwr", cap_w[1].size(), 8);
      if (cap_w[1].size() == 8) chk("stall.B.wn0", 32'(cap_w[1][0]), 4);
      chk("stall.A.ntag", n_tag[0], 1);
      clear_caps();

      // Misses during FILL and TAG are ignored; a miss in the first IDLE cycle is taken.
      miss_ab = 1'b1; addr_ab = 16'h2000;
      step();
      miss_ab = 1'b0;
      repeat (3) step();
      miss_ab = 1'b1; addr_ab = 16'h3000;
      step();
      miss_ab = 1'b0;
      t = 0;
      while ((phase[0] != 2) && (t < 100)) begin
         step();
         t++;
      end
      chk("ign.tag_timeout", 32'(t >= 100), 0);
      miss_ab = 1'b1; addr_ab = 16'h3000;
      step();
      addr_ab = 16'h5554;
      step();
      miss_ab = 1'b0;
      wait_idle("ign");
      chk("ign.A.ntag", n_tag[0], 2);
      chk("ign.B.ntag", n_tag[1], 2);
      chk("ign.A.nreq", cap_a[0].size(), 16);
      if ((cap_a[0].size() == 16) && (cap_a[1].size() == 16)) begin
         chk("ign.A.addr0", cap_a[0][0], 32'h2000);
         chk("ign.A.addr8", cap_a[0][8], 32'h5550);
         chk("ign.B.addr8", cap_a[1][8], 32'h5554);
      end
      if (cap_w[1].size() == 16) chk("ign.B.wn8", 32'(cap_w[1][8]), 2);
      clear_caps();

      // Reset after the 4th write aborts the fill without a tag write.
      miss_ab = 1'b1; addr_ab = 16'h1236;
      step();
      miss_ab = 1'b0;
      t = 0;
      while ((cap_w[0].size() < 4) && (t < 100)) begin
         step();
         t++;
      end
      chk("rst.wr_timeout", 32'(t >= 100), 0);
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
      chk("rst.A.nwr", cap_w[0].size(), 4);
      chk("rst.A.ntag", n_tag[0], 0);
      chk("rst.B.ntag", n_tag[1], 0);
      clear_caps();
      miss_ab = 1'b1; addr_ab = 16'h1236;
      step();
      miss_ab = 1'b0;
      wait_idle("rst2");
      if ((cap_w[0].size() > 0) && (cap_w[1].size() > 0)) begin
         chk("rst2.A.wn0", 32'(cap_w[0][0]), 0);
         chk("rst2.B.wn0", 32'(cap_w[1][0]), 3);
      end
      chk("rst2.A.nwr", cap_w[0].size(), 8);
      chk("rst2.A.ntag", n_tag[0], 1);
      clear_caps();

      // 32-bit words, 4-word block, critical word first.
      miss_c = 1'b1; addr_c = 32'h0000_100C;
      step();
      miss_c = 1'b0;
      wait_idle("c");
      chk("c.nreq", cap_a[2].size(), 4);
      if (cap_a[2].size() == 4) begin
         for (int k = 0; k < 4; k++) chk("c.addr_tbl", cap_a[2][k], c_addr[k]);
      end
      if (cap_w[2].size() == 4) begin
         for (int k = 0; k < 4; k++) chk("c.wn_tbl", 32'(cap_w[2][k]), 32'(c_wn[k]));
      end
      chk("c.ntag", n_tag[2], 1);
      chk("c.ncrit", n_crit[2], 1);
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised cache miss-fill controller between the cache tag/data arrays and the multi-cycle main memory. On a detected miss, it issues one read request per memory word of the block, with requests pipelined back-to-back. It writes each returning word into the data array, then writes the tag/valid bit. Supports generic block size and data width, and an optional critical-word-first order that signals when the missed word itself has arrived.

## Interface
- ADDR_W, 16, address width (byte addresses)
- DATA_W, 16, memory word width; power of two, at least 8
- WORDS, 8, words per cache block; power of two, at least 2
- CWF, 0, 1 = critical-word-first wrap order, 0 = ascending from word 0
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- miss_detected  in  1  tag logic reports a miss; sampled only in IDLE
- miss_address  in  ADDR_W  missing byte address; sampled with miss_detected
- mem_req_ready  in  1  memory accepts a request this cycle
- memory_data  in  DATA_W  returned read data
- memory_data_valid  in  1  memory_data valid; responses return in request order
- mem_req_valid  out  1  read request valid
- memory_address  out  ADDR_W  request address, word-aligned
- fsm_busy  out  1  pipeline stall
- write_data_array  out  1  data-array write enable
- word_num  out  log2(WORDS)  data-array word index for the current write
- fill_data  out  DATA_W  data-array write data (memory_data passed through)
- write_tag_array  out  1  tag/valid write enable, one cycle
- crit_word_valid  out  1  one-cycle pulse when the missed word is written

## Operation
- Derived widths: BOFF = log2(DATA_W/8) and WOFF = log2(WORDS). The block base is miss_address with its low BOFF+WOFF bits cleared. The start word is miss_address[BOFF+WOFF-1:BOFF] if CWF=1, otherwise 0.
- States:
  - IDLE: if miss_detected, latch base and start word, clear both counters, go to FILL.
  - FILL: issue and collect words. When the WORDS-th response is accepted, go to TAG.
  - TAG: assert write_tag_array, then go to IDLE.
- Issue counter (req_cnt, 0..WORDS):
  - mem_req_valid = FILL && req_cnt < WORDS.
  - memory_address = base + (((start + req_cnt) mod WORDS) << BOFF). The word index wraps modulo WORDS and never carries into the tag bits.
  - req_cnt increments on mem_req_valid && mem_req_ready.
- Return counter (rsp_cnt, 0..WORDS):
  - A response is accepted when FILL && memory_data_valid && rsp_cnt < req_cnt.
  - On acceptance: write_data_array=1, word_num = (start + rsp_cnt) mod WORDS, rsp_cnt increments.
  - crit_word_valid is asserted on acceptance when rsp_cnt==0, i.e. the word that missed arrives first in CWF mode. In CWF=0 mode this is word 0.
- Responses are ignored with no write in IDLE, in TAG, and when rsp_cnt == req_cnt (spurious responses).
- fsm_busy = (state != IDLE) || miss_detected. The stall is therefore combinational in the miss cycle.
- miss_detected while in FILL or TAG is ignored. The tag logic re-asserts it after the fill completes.

## Timing
- Reset values:
  - state IDLE; counters 0; latched base and start 0.
  - Outputs all 0 (fsm_busy follows miss_detected).
- Request issue:
  - Miss in cycle 0 → first mem_req_valid in cycle 1.
  - With mem_req_ready held high, requests go out in cycles 1..WORDS, one per cycle.
- Memory latency is arbitrary (at least 1 cycle after the request). A response accepted in cycle k is written in cycle k; there is no internal buffering.
- Fill end:
  - Last response accepted in cycle n → write_tag_array in cycle n+1 → IDLE in cycle n+2.
  - A new miss is accepted in cycle n+2.
- A request and a response in the same cycle both update their counters.
- mem_req_ready low holds memory_address and mem_req_valid stable.
- Reset asserted mid-fill: immediately IDLE, all outputs 0, no tag write; partial data-array contents remain invalid.

## Structure
- Package cache_fill_pkg:
  - state encoding (IDLE, FILL, TAG)
  - functions for BOFF/WOFF
  - default parameter constants
- One sub-module, fill_word_ctr: saturating log2(WORDS)+1-bit counter with clear and increment enable. It is instantiated twice, for req_cnt and rsp_cnt.

## Test plan
- Default params, CWF=0, miss at 0x1236, ready=1, 3-cycle latency:
  - requests 0x1230, 0x1232, … 0x123E;
  - writes word_num 0..7;
  - write_tag_array one cycle after the 8th write;
  - fsm_busy high from the miss cycle through the tag cycle.
- CWF=1, miss at 0x1236:
  - request order 0x1236, 0x1238 … 0x123E, 0x1230 … 0x1234;
  - word_num 3,4,5,6,7,0,1,2;
  - crit_word_valid only on the first write.
- Random mem_req_ready stalls plus a spurious memory_data_valid in IDLE:
  - address held while stalled;
  - exactly 8 data writes;
  - no write for the spurious response.
- miss_detected pulsed during FILL and during TAG: ignored, one tag write only; a new miss in the first IDLE cycle starts a fresh fill.
- rst asserted after the 4th write: all outputs 0 in the same cycle, no write_tag_array; the next miss restarts from word_num = start.
- DATA_W=32, WORDS=4, ADDR_W=32, miss 0x0000_100C with CWF=1: addresses 0x100C, 0x1000, 0x1004, 0x1008.
